// File: rtl/mac_accumulator_8x8.sv
// Burst dot-product accumulator around an 8x8 Wallace multiplier built from 4:2 compressors.
// Optional build macro: SATURATE_EN clamps the accumulator at all-ones on carry out instead of wrapping.

module compressor_42_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] x2_i,
    input  logic [W-1:0] x3_i,
    input  logic [W-1:0] x4_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);
    logic [W-1:0] s1;
    logic [W-1:0] cin;

    // The lateral carry depends only on the first three inputs of the lower bit, so there is no ripple chain.
    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        s1      = x1_i ^ x2_i ^ x3_i;
        cin     = '0;
        carry_o = '0;
        for (int i = 1; i < W; i++) begin
            cin[i]     = (x1_i[i-1] & x2_i[i-1]) | (x1_i[i-1] & x3_i[i-1]) | (x2_i[i-1] & x3_i[i-1]);
            carry_o[i] = (s1[i-1] & x4_i[i-1]) | (s1[i-1] & cin[i-1]) | (x4_i[i-1] & cin[i-1]);
        end
        sum_o = s1 ^ x4_i ^ cin;
    end
endmodule

module wallace_using_4x2compressor (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [15:0] pp [8];
    logic [15:0] s_lo, c_lo, s_hi, c_hi, s_fin, c_fin;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'd0, a_i & {8{b_i[i]}}} << i;
        end
    end

    compressor_42_row #(.W(16)) u_lo (
        .x1_i(pp[0]), .x2_i(pp[1]), .x3_i(pp[2]), .x4_i(pp[3]),
        .sum_o(s_lo), .carry_o(c_lo)
    );
    compressor_42_row #(.W(16)) u_hi (
        .x1_i(pp[4]), .x2_i(pp[5]), .x3_i(pp[6]), .x4_i(pp[7]),
        .sum_o(s_hi), .carry_o(c_hi)
    );
    compressor_42_row #(.W(16)) u_fin (
        .x1_i(s_lo), .x2_i(c_lo), .x3_i(s_hi), .x4_i(c_hi),
        .sum_o(s_fin), .carry_o(c_fin)
    );

    // The true product fits in 16 bits, so dropping carries beyond bit 15 is exact.
    assign p_o = s_fin + c_fin;
endmodule

module mac_accumulator_8x8 #(
    parameter int ACC_W   = 20,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      prod_q, prod_d;
    logic             prod_v_q;
    logic [ACC_W:0]   sum;
    logic             beat;

    wallace_using_4x2compressor u_mul (
        .a_i(a),
        .b_i(b),
        .p_o(prod_d)
    );

    assign in_ready  = (state_q == RUN) && (count_q < N_LAST);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

    // The extra top bit of sum is the carry out that flags overflow.
    assign sum = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (prod_v_q) begin
`ifdef SATURATE_EN
                    acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
                end
                // Leave only once the last captured product has been added.
                if ((count_q == N_LAST) && !prod_v_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            prod_v_q <= beat;
            if (beat) begin
                prod_q <= prod_d;
            end
        end
    end
endmodule
